// File: rtl/pipeline_pkg.sv
// Shared constants for the 3-stage (A + B + C - D) * D arithmetic pipeline.
package pipeline_pkg;

    localparam int PIPE_DEFAULT_N = 10;
    localparam int PIPE_LATENCY   = 3;

endpackage : pipeline_pkg

// File: rtl/pipe_reg.sv
// Parameterised-width D flip-flop bank with asynchronous active-low clear,
// used for every stage register of the pipeline.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage register: cleared immediately on reset, otherwise loads every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule : pipe_reg

// File: rtl/pipeline.sv
// 3-stage pipelined datapath F = (A + B + C - D) * D, modulo 2^N, latency 3.
// Optional valid tracking (in_valid/out_valid) is enabled by PIPELINE_VALID_EN.
module pipeline
    import pipeline_pkg::*;
#(
    parameter int N = PIPE_DEFAULT_N
) (
    output logic [N-1:0] F,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic         clk,
    input  logic         rst_n
`ifdef PIPELINE_VALID_EN
    ,
    input  logic         in_valid,
    output logic         out_valid
`endif
);

    logic [N-1:0] s1_ab_s;
    logic [N-1:0] s1_cd_s;
    logic [N-1:0] s2_sum_s;
    logic [N-1:0] f_s;

    logic [N-1:0] s1_ab_r;
    logic [N-1:0] s1_cd_r;
    logic [N-1:0] s1_d_r;
    logic [N-1:0] s2_sum_r;
    logic [N-1:0] s2_d_r;

    // Stage arithmetic; every result is taken modulo 2^N. The N-bit product
    // equals the low N bits of the full 2N-bit product.
    always_comb begin
        s1_ab_s  = A + B;
        s1_cd_s  = C - D;
        s2_sum_s = s1_ab_r + s1_cd_r;
        f_s      = s2_sum_r * s2_d_r;
    end

    pipe_reg #(.W(N)) u_s1_ab (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s1_ab_s),
        .q     (s1_ab_r)
    );

    pipe_reg #(.W(N)) u_s1_cd (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s1_cd_s),
        .q     (s1_cd_r)
    );

    pipe_reg #(.W(N)) u_s1_d (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (D),
        .q     (s1_d_r)
    );

    pipe_reg #(.W(N)) u_s2_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s2_sum_s),
        .q     (s2_sum_r)
    );

    pipe_reg #(.W(N)) u_s2_d (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s1_d_r),
        .q     (s2_d_r)
    );

    pipe_reg #(.W(N)) u_f (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (f_s),
        .q     (F)
    );

`ifdef PIPELINE_VALID_EN
    // Valid bit travels alongside the data; the data path ignores it.
    logic [PIPE_LATENCY-1:0] vld_r;

    pipe_reg #(.W(PIPE_LATENCY)) u_vld (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({vld_r[PIPE_LATENCY-2:0], in_valid}),
        .q     (vld_r)
    );

    assign out_valid = vld_r[PIPE_LATENCY-1];
`endif

endmodule : pipeline

// File: tb/tb_pipeline.sv
// Scoreboard bench for pipeline: the driver queues hand-computed results,
// the monitor pops and compares them when they reach the output stage.
module tb_pipeline;
    import pipeline_pkg::*;

    localparam int N = PIPE_DEFAULT_N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] A, B, C, D, F;
    logic         issue;
    logic [2:0]   tb_vld;
    logic [N-1:0] exp_q[$];
    int           checks   = 0;
    int           failures = 0;

`ifdef PIPELINE_VALID_EN
    logic in_valid;
    logic out_valid;
    assign in_valid = issue;
`endif

    always #5 clk = ~clk;

    pipeline #(.N(N)) dut (
        .F         (F),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .clk       (clk),
        .rst_n     (rst_n)
`ifdef PIPELINE_VALID_EN
        ,
        .in_valid  (in_valid),
        .out_valid (out_valid)
`endif
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side latency tracker: marks which output cycles carry an issued set.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_vld <= 3'b000;
        else        tb_vld <= {tb_vld[1:0], issue};
    end

    // Monitor: compare F against the scoreboard, or against zero when idle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tb_vld[2]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: got F=%0d expected a queued result", F);
                end else begin
                    check("result", F, exp_q.pop_front());
                end
            end else begin
                check("idle_zero", F, {N{1'b0}});
            end
`ifdef PIPELINE_VALID_EN
            checks++;
            if (out_valid !== tb_vld[2]) begin
                failures++;
                $display("FAIL out_valid: got %b expected %b at %0t", out_valid, tb_vld[2], $time);
            end
`endif
        end
    end

    task automatic drive(input int a, input int b, input int c, input int d, input logic v);
        @(posedge clk);
        #1;
        A = a[N-1:0];
        B = b[N-1:0];
        C = c[N-1:0];
        D = d[N-1:0];
        issue = v;
    endtask

    task automatic send(input int a, input int b, input int c, input int d, input int e);
        drive(a, b, c, d, 1'b1);
        exp_q.push_back(e[N-1:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        issue = 1'b0;
        A = 10'd5; B = 10'd6; C = 10'd7; D = 10'd3;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset held with nonzero inputs across clock edges.
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", F, {N{1'b0}});
        end
        A = '0; B = '0; C = '0; D = '0;
        rst_n = 1'b1;
        idle(2);

        send(1, 2, 3, 4, 8);
        idle(3);

        send(0, 3, 5, 2, 12);
        send(1, 0, 1, 1, 1);
        send(2, 2, 2, 2, 8);
        send(0, 0, 0, 1, 1023);
        send(1023, 1023, 1023, 2, 1014);
        send(100, 200, 300, 7, 55);
        idle(4);

        // Three sets in flight; reset lands mid-cycle while F already shows 8.
        send(1, 2, 3, 4, 8);
        send(5, 5, 5, 5, 50);
        send(0, 0, 0, 1, 1023);
        idle(1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_clear", F, {N{1'b0}});
`ifdef PIPELINE_VALID_EN
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_clear_valid: got %b expected 0", out_valid);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        send(2, 2, 2, 2, 8);
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline
